// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader_pkg
//  Purpose  : State encodings, field widths and helpers shared by the loader.
//  Revision : 1.0  initial release
// ============================================================================
package program_loader_pkg;

    localparam int c_LEN_W      = 16;
    localparam int c_BYTE_CNT_W = 2;
    localparam int c_STATE_W    = 3;

    localparam logic [c_STATE_W-1:0] c_ST_LEN_HI = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_LEN_LO = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DATA   = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_CHECK  = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_DONE   = 3'd4;
    localparam logic [c_STATE_W-1:0] c_ST_ERROR  = 3'd5;

    typedef logic [c_LEN_W-1:0] len_t;

    // A word count may equal the memory depth but never exceed it.
    function automatic logic len_too_big(input len_t len, input int addr_width);
        return {1'b0, len} > (17'(1) << addr_width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/program_loader_byte_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : byte_assembler
//  Purpose  : Packs accepted bytes big-endian into 32-bit words.
//  Revision : 1.0  initial release
// ============================================================================
module byte_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    // The three oldest bytes are stored; the fourth completes the word on the fly
    // so the word is usable in the very cycle its last byte is accepted.
    logic [23:0]             r_shift;
    logic [c_BYTE_CNT_W-1:0] r_cnt;

    assign word       = {r_shift, byte_in};
    assign word_valid = accept && (r_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (accept) begin
            r_shift <= word[23:0];
            r_cnt   <= r_cnt + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader
//  Purpose  : Boot-stream loader writing instruction memory, then releasing CPU.
//             Optional checksum trailer enabled by macro LOADER_CHECKSUM_EN.
//  Revision : 1.0  initial release
// ============================================================================
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
)
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

`ifdef LOADER_CHECKSUM_EN
    localparam logic [c_STATE_W-1:0] c_ST_AFTER_PAYLOAD = c_ST_CHECK;
    logic [31:0] r_csum;
`else
    localparam logic [c_STATE_W-1:0] c_ST_AFTER_PAYLOAD = c_ST_DONE;
`endif

    logic [c_STATE_W-1:0]  r_state;
    logic [c_STATE_W-1:0]  w_state_next;
    logic                  w_rx_state;
    logic                  w_accept;
    logic                  w_len_clear;
    logic                  w_word_valid;
    logic                  w_data_word;
    logic [31:0]           w_word;
    len_t                  w_len;
    len_t                  r_words_left;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic                  r_cpu_reset;
    logic                  r_done;
    logic                  r_error;

    always_comb begin
        w_rx_state = 1'b0;
        case (r_state)
            c_ST_LEN_HI, c_ST_LEN_LO, c_ST_DATA: w_rx_state = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            c_ST_CHECK:                          w_rx_state = 1'b1;
`endif
            default:                             w_rx_state = 1'b0;
        endcase
    end

    assign in_ready    = w_rx_state && !reset;
    assign w_accept    = in_valid && in_ready;
    assign w_len_clear = w_accept && (r_state == c_ST_LEN_LO);
    assign w_data_word = w_word_valid && (r_state == c_ST_DATA);
    assign w_len       = w_word[c_LEN_W-1:0];

    // Shared packer: LEN_HI/LEN_LO fill the low half, then it is cleared for payload.
    byte_assembler u_byte_assembler (
        .clk        (clock),
        .rst        (reset),
        .clear      (w_len_clear),
        .accept     (w_accept),
        .byte_in    (in_data),
        .word       (w_word),
        .word_valid (w_word_valid)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_LEN_HI: begin
                if (w_accept) w_state_next = c_ST_LEN_LO;
            end
            c_ST_LEN_LO: begin
                if (w_accept) begin
                    if (w_len == '0)
                        w_state_next = c_ST_AFTER_PAYLOAD;
                    else if (len_too_big(w_len, ADDR_WIDTH))
                        w_state_next = c_ST_ERROR;
                    else
                        w_state_next = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_word_valid && (r_words_left == c_LEN_W'(1)))
                    w_state_next = c_ST_AFTER_PAYLOAD;
            end
`ifdef LOADER_CHECKSUM_EN
            c_ST_CHECK: begin
                if (w_word_valid)
                    w_state_next = (w_word == r_csum) ? c_ST_DONE : c_ST_ERROR;
            end
`endif
            default: w_state_next = r_state;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_ST_LEN_HI;
            r_words_left <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_reset  <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_mem_we <= w_data_word;
            if (w_data_word)
                r_mem_wdata <= w_word;
            // Address advances in the cycle after each strobe so it is stable during it.
            if (r_mem_we)
                r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
            if (w_len_clear)
                r_words_left <= w_len;
            else if (w_data_word)
                r_words_left <= r_words_left - c_LEN_W'(1);
            // done/cpu_reset lag DONE by one cycle so they follow the final write strobe.
            r_done      <= (r_state == c_ST_DONE);
            r_cpu_reset <= (r_state != c_ST_DONE);
            r_error     <= (w_state_next == c_ST_ERROR);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (reset)
            r_csum <= '0;
        else if (w_data_word)
            r_csum <= r_csum ^ w_word;
    end
`endif

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_reset = r_cpu_reset;
    assign done      = r_done;
    assign error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_program_loader
//  Purpose  : Directed self-checking bench for program_loader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_program_loader;

    localparam int ADDR_WIDTH = 10;

    logic                  clock;
    logic                  reset;
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  cpu_reset;
    logic                  done;
    logic                  error;

    program_loader #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_pass   = 0;

    int        ncyc     = 0;
    int        acc_q[$];
    int        we_cyc_q[$];
    int        we_addr_q[$];
    logic [31:0] we_data_q[$];
    int        done_cyc = -1;
    int        rel_cyc  = -1;

    logic [7:0] stream34 [10];

    // Monitor at the falling edge: outputs are settled, inputs are stable until the next rise.
    always @(negedge clock) begin
        ncyc = ncyc + 1;
        if (in_valid && in_ready) acc_q.push_back(ncyc);
        if (mem_we) begin
            we_cyc_q.push_back(ncyc);
            we_addr_q.push_back(int'(mem_addr));
            we_data_q.push_back(mem_wdata);
        end
        if (done && done_cyc < 0) done_cyc = ncyc;
        if (!cpu_reset && rel_cyc < 0) rel_cyc = ncyc;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic clear_logs();
        acc_q.delete();
        we_cyc_q.delete();
        we_addr_q.delete();
        we_data_q.delete();
        done_cyc = -1;
        rel_cyc  = -1;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  waited = 0;
        bit  ok     = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!ok && waited < 50) begin
            @(negedge clock);
            if (in_ready) ok = 1;
            else waited++;
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic send_prefix(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            send_byte(stream34[i]);
            repeat (gap) begin
                @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Expected: two writes, 0x12345678 @0 and 0x9ABCDEF0 @1, each one cycle after its 4th byte.
    task automatic check_writes(input string pfx);
        check({pfx, "_nwrites"}, 32'(we_cyc_q.size()), 32'd2);
        if (we_cyc_q.size() >= 2 && acc_q.size() >= 10) begin
            check({pfx, "_addr0"}, 32'(we_addr_q[0]), 32'd0);
            check({pfx, "_data0"}, we_data_q[0], 32'h12345678);
            check({pfx, "_addr1"}, 32'(we_addr_q[1]), 32'd1);
            check({pfx, "_data1"}, we_data_q[1], 32'h9ABCDEF0);
            check({pfx, "_we0_lat"}, 32'(we_cyc_q[0] - acc_q[5]), 32'd1);
            check({pfx, "_we1_lat"}, 32'(we_cyc_q[1] - acc_q[9]), 32'd1);
`ifndef LOADER_CHECKSUM_EN
            check({pfx, "_done_lat"}, 32'(done_cyc - we_cyc_q[1]), 32'd1);
            check({pfx, "_cpurel_lat"}, 32'(rel_cyc - we_cyc_q[1]), 32'd1);
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_acc_before;
        int n_we_before;
        stream34[0] = 8'h00; stream34[1] = 8'h02;
        stream34[2] = 8'h12; stream34[3] = 8'h34; stream34[4] = 8'h56; stream34[5] = 8'h78;
        stream34[6] = 8'h9A; stream34[7] = 8'hBC; stream34[8] = 8'hDE; stream34[9] = 8'hF0;

        // Reset state, with a byte presented that must not be taken.
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        idle(3);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        @(negedge clock);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_done",      32'(done),      32'd0);
        check("rst_error",     32'(error),     32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_mem_wdata", mem_wdata,      32'd0);
        apply_reset();

        // Contiguous two-word load.
        send_prefix(10, 0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h88888888);
`endif
        idle(4);
        check_writes("b2b");
        check("b2b_done",      32'(done),      32'd1);
        check("b2b_cpu_reset", 32'(cpu_reset), 32'd0);
        check("b2b_in_ready",  32'(in_ready),  32'd0);
        check("b2b_done_from_last_acc", 32'(done_cyc - acc_q[acc_q.size()-1]), 32'd2);
        // Bytes while not ready are ignored and DONE holds.
        n_acc_before = acc_q.size();
        n_we_before  = we_cyc_q.size();
        in_data  = 8'h55;
        in_valid = 1'b1;
        idle(4);
        in_valid = 1'b0;
        check("ign_accepts", 32'(acc_q.size()), 32'(n_acc_before));
        check("ign_writes",  32'(we_cyc_q.size()), 32'(n_we_before));
        check("ign_done",    32'(done), 32'd1);

        // Zero-length image.
        apply_reset();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h00000000);
`endif
        idle(3);
        check("len0_writes",   32'(we_cyc_q.size()), 32'd0);
        check("len0_done",     32'(done),     32'd1);
        check("len0_in_ready", 32'(in_ready), 32'd0);
        check("len0_cpu_reset", 32'(cpu_reset), 32'd0);

        // One word beyond memory depth.
        apply_reset();
        send_byte(8'h04);
        send_byte(8'h01);
        idle(3);
        check("ovf_error",     32'(error),     32'd1);
        check("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
        check("ovf_done",      32'(done),      32'd0);
        check("ovf_in_ready",  32'(in_ready),  32'd0);
        check("ovf_writes",    32'(we_cyc_q.size()), 32'd0);

        // Exactly memory depth is accepted as a length.
        apply_reset();
        send_byte(8'h04);
        send_byte(8'h00);
        idle(2);
        check("max_error",    32'(error),    32'd0);
        check("max_in_ready", 32'(in_ready), 32'd1);

        // in_valid toggled every other cycle.
        apply_reset();
        send_prefix(10, 1);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h88888888);
`endif
        idle(4);
        check_writes("gap");
        check("gap_done", 32'(done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // Corrupted trailer.
        apply_reset();
        send_prefix(10, 0);
        send_word(32'h88888889);
        idle(3);
        check("csum_bad_error", 32'(error), 32'd1);
        check("csum_bad_done",  32'(done),  32'd0);
        check("csum_bad_cpu_reset", 32'(cpu_reset), 32'd1);
`endif

        // Reset after six payload bytes, then reload.
        apply_reset();
        send_prefix(8, 0);
        idle(1);
        check("abort_writes", 32'(we_cyc_q.size()), 32'd1);
        if (we_data_q.size() >= 1) check("abort_data0", we_data_q[0], 32'h12345678);
        reset    = 1'b1;
        in_valid = 1'b0;
        idle(2);
        check("abort_no_partial", 32'(we_cyc_q.size()), 32'd1);
        apply_reset();
        send_prefix(10, 0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h88888888);
`endif
        idle(4);
        check_writes("reload");
        check("reload_done", 32'(done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
